// File: rtl/gray_ctrl_pkg.sv
// Shared definitions for the gray-counter step controller: FSM encoding and
// the reference 3-bit gray sequence the counter walks through.
package gray_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [2:0] GRAY_SEQ [0:7] = '{
        3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100
    };

    function automatic logic [2:0] gray_at(input logic [2:0] idx);
        return GRAY_SEQ[idx];
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter, purely combinational; on a tie the requester
// that did not win last time is chosen. The pointer lives in the caller.
module rr_arb2 (
    input  logic [1:0] Req,
    input  logic       LastGnt,
    output logic [1:0] Win
);

    always_comb begin
        Win = 2'b00;
        case (Req)
            2'b01:   Win = 2'b01;
            2'b10:   Win = 2'b10;
            2'b11:   Win = LastGnt ? 2'b01 : 2'b10;
            default: Win = 2'b00;
        endcase
    end

endmodule

// File: rtl/gray_step_ctrl.sv
// Shares one gray counter between two requesters: optional clear, N enable
// pulses, then returns the final value. Done arrives 1+Clr+Len+1 cycles after grant.
module gray_step_ctrl
    import gray_ctrl_pkg::*;
#(
    parameter int LEN_W = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [1:0]       Req,
    input  logic [LEN_W-1:0] Len0,
    input  logic [LEN_W-1:0] Len1,
    input  logic [1:0]       Clr,
    input  logic [2:0]       CntOutput,
    input  logic             CntOverflow,
    output logic             CntReset,
    output logic             CntEn,
    output logic [1:0]       Gnt,
    output logic [1:0]       Done,
    output logic [2:0]       Result,
    output logic             ResOvf,
    output logic             Busy
);

    state_t           state;
    state_t           next_state;
    logic             last_gnt;
    logic [LEN_W-1:0] step_cnt;
    logic [1:0]       win;
    logic             win_clr;
    logic [LEN_W-1:0] win_len;

    rr_arb2 u_arb (
        .Req     (Req),
        .LastGnt (last_gnt),
        .Win     (win)
    );

    always_comb begin
        win_clr    = win[1] ? Clr[1] : Clr[0];
        win_len    = win[1] ? Len1   : Len0;
        next_state = state;
        case (state)
            S_IDLE: begin
                if (|Req) begin
                    if (win_clr)
                        next_state = S_CLEAR;
                    else if (win_len != '0)
                        next_state = S_RUN;
                    else
                        next_state = S_DONE;
                end
            end
            S_CLEAR: next_state = (step_cnt != '0) ? S_RUN : S_DONE;
            // step_cnt==1 marks the last enabled cycle; the counter settles in DONE
            S_RUN:   if (step_cnt == LEN_W'(1)) next_state = S_DONE;
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state    <= S_IDLE;
            last_gnt <= 1'b1;
            step_cnt <= '0;
            Gnt      <= 2'b00;
            Done     <= 2'b00;
            Result   <= 3'b000;
            ResOvf   <= 1'b0;
            CntReset <= 1'b0;
            CntEn    <= 1'b0;
        end else begin
            state    <= next_state;
            CntReset <= (next_state == S_CLEAR);
            CntEn    <= (next_state == S_RUN);
            Done     <= 2'b00;
            case (state)
                S_IDLE: begin
                    if (|Req) begin
                        Gnt      <= win;
                        last_gnt <= win[1];
                        step_cnt <= win_len;
                    end
                end
                S_RUN: step_cnt <= step_cnt - LEN_W'(1);
                S_DONE: begin
                    Result <= CntOutput;
                    ResOvf <= CntOverflow;
                    Done   <= Gnt;
                    Gnt    <= 2'b00;
                end
                default: ;
            endcase
        end
    end

    assign Busy = (state != S_IDLE);

endmodule

// File: tb/tb_gray_step_ctrl.sv
// Bench for gray_step_ctrl with a behavioural 3-bit gray counter attached.
// Directed vectors with hand-computed results plus reset and arbitration sequences.
module tb_gray_step_ctrl;
    import gray_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] req;
    logic [3:0] len0;
    logic [3:0] len1;
    logic [1:0] clr;
    logic [2:0] cnt_output;
    logic       cnt_overflow;
    logic       cnt_reset;
    logic       cnt_en;
    logic [1:0] gnt;
    logic [1:0] done;
    logic [2:0] result;
    logic       res_ovf;
    logic       busy;

    always #5 clk = ~clk;

    gray_step_ctrl #(.LEN_W(4)) dut (
        .Clk         (clk),
        .Reset       (rst_n),
        .Req         (req),
        .Len0        (len0),
        .Len1        (len1),
        .Clr         (clr),
        .CntOutput   (cnt_output),
        .CntOverflow (cnt_overflow),
        .CntReset    (cnt_reset),
        .CntEn       (cnt_en),
        .Gnt         (gnt),
        .Done        (done),
        .Result      (result),
        .ResOvf      (res_ovf),
        .Busy        (busy)
    );

    // counter instantiated above the controller: sync reset, sticky overflow
    logic [2:0] cnt_pos = 3'd0;
    logic       cnt_ovf_q = 1'b0;
    always @(posedge clk) begin
        if (cnt_reset) begin
            cnt_pos   <= 3'd0;
            cnt_ovf_q <= 1'b0;
        end else if (cnt_en) begin
            cnt_pos <= cnt_pos + 3'd1;
            if (cnt_pos == 3'd7) cnt_ovf_q <= 1'b1;
        end
    end
    assign cnt_output   = gray_at(cnt_pos);
    assign cnt_overflow = cnt_ovf_q;

    int checks = 0;
    int fails  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt"},  32'(gnt), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_res"},  32'(result), 0);
        check({tag, "_ovf"},  32'(res_ovf), 0);
        check({tag, "_crst"}, 32'(cnt_reset), 0);
        check({tag, "_cen"},  32'(cnt_en), 0);
        check({tag, "_busy"}, 32'(busy), 0);
    endtask

    // One burst for a single requester; the other requester's Len/Clr carry decoys.
    task automatic run_burst(input int who, input logic c, input logic [3:0] l,
                             input logic [2:0] er, input logic eo, input int el,
                             input string tag);
        int  en_cnt;
        int  rst_cnt;
        int  lat;
        bit  got;
        bit  overlap;
        en_cnt = 0; rst_cnt = 0; lat = 0; got = 0; overlap = 0;
        @(negedge clk);
        req = 2'b00;
        req[who] = 1'b1;
        if (who == 0) begin
            len0 = l; len1 = ~l; clr = {~c, c};
        end else begin
            len1 = l; len0 = ~l; clr = {c, ~c};
        end
        for (int k = 1; k <= 40 && !got; k++) begin
            @(negedge clk);
            if (k == 1) begin
                check({tag, "_gnt"}, 32'(gnt), 32'(1 << who));
                check({tag, "_busy"}, 32'(busy), 1);
            end
            if (cnt_en) en_cnt++;
            if (cnt_reset) rst_cnt++;
            if (cnt_en && cnt_reset) overlap = 1;
            if (done != 2'b00) begin
                got = 1;
                lat = k;
                check({tag, "_done"}, 32'(done), 32'(1 << who));
                check({tag, "_result"}, 32'(result), 32'(er));
                check({tag, "_resovf"}, 32'(res_ovf), 32'(eo));
                check({tag, "_gnt_clr"}, 32'(gnt), 0);
                req = 2'b00;
            end
        end
        check({tag, "_done_seen"}, 32'(got), 1);
        check({tag, "_latency"}, 32'(lat), 32'(el));
        check({tag, "_en_cycles"}, 32'(en_cnt), 32'(l));
        check({tag, "_rst_cycles"}, 32'(rst_cnt), 32'(c));
        check({tag, "_overlap"}, 32'(overlap), 0);
    endtask

    typedef struct {
        int         who;
        logic       clr;
        logic [3:0] len;
        logic [2:0] exp_res;
        logic       exp_ovf;
        int         exp_lat;
    } vec_t;

    vec_t vecs [7];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{0, 1'b1, 4'd3,  3'b010, 1'b0, 6};
        vecs[1] = '{1, 1'b1, 4'd8,  3'b000, 1'b1, 11};
        vecs[2] = '{0, 1'b1, 4'd4,  3'b110, 1'b0, 7};
        vecs[3] = '{1, 1'b0, 4'd5,  3'b001, 1'b1, 7};
        vecs[4] = '{0, 1'b0, 4'd0,  3'b001, 1'b1, 2};
        vecs[5] = '{1, 1'b1, 4'd0,  3'b000, 1'b0, 3};
        vecs[6] = '{0, 1'b0, 4'd15, 3'b100, 1'b1, 17};

        rst_n = 1'b0; req = 2'b00; clr = 2'b00; len0 = 4'd0; len1 = 4'd0;
        #2;
        check_all_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++)
            run_burst(vecs[i].who, vecs[i].clr, vecs[i].len, vecs[i].exp_res,
                      vecs[i].exp_ovf, vecs[i].exp_lat, $sformatf("vec%0d", i));

        // async reset in the middle of a 7-step burst
        @(negedge clk);
        req = 2'b01; clr = 2'b01; len0 = 4'd7;
        begin
            int waited;
            waited = 0;
            while (!cnt_en && waited < 20) begin
                @(negedge clk);
                waited++;
            end
            check("midrun_en_seen", 32'(cnt_en), 1);
        end
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("midrun");
        req = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        run_burst(0, 1'b1, 4'd1, 3'b001, 1'b0, 4, "after_rst");

        // both requesters held after reset: owners alternate 0,1,0,1 back to back
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        begin
            logic [1:0] exp_done [4];
            logic [2:0] exp_res  [4];
            int         exp_gap  [4];
            int         n_done;
            int         gap;
            bit         both_gnt;
            exp_done = '{2'b01, 2'b10, 2'b01, 2'b10};
            exp_res  = '{3'b011, 3'b110, 3'b111, 3'b100};
            exp_gap  = '{3, 4, 3, 4};
            n_done = 0; gap = 0; both_gnt = 0;
            req = 2'b11; clr = 2'b00; len0 = 4'd1; len1 = 4'd2;
            for (int k = 0; k < 100 && n_done < 4; k++) begin
                @(negedge clk);
                gap++;
                if (gnt == 2'b11) both_gnt = 1;
                if (done != 2'b00) begin
                    check($sformatf("rr%0d_done", n_done), 32'(done), 32'(exp_done[n_done]));
                    check($sformatf("rr%0d_result", n_done), 32'(result), 32'(exp_res[n_done]));
                    check($sformatf("rr%0d_gap", n_done), 32'(gap), 32'(exp_gap[n_done]));
                    n_done++;
                    gap = 0;
                end
            end
            req = 2'b00;
            check("rr_done_count", 32'(n_done), 4);
            check("rr_gnt_never_11", 32'(both_gnt), 0);
        end

        repeat (3) @(negedge clk);
        check("idle_busy", 32'(busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/gray_step_ctrl.md
# gray_step_ctrl

Sequencing controller for the 3-bit gray-code counter. It shares one counter between two requesters, granting them round-robin. For each grant it optionally clears the counter, pulses the counter enable for a requested number of steps, then returns the final gray value and overflow status to the owner. It sits between the requesting logic and the counter's `Reset`/`En` inputs and consumes the counter's `Output`/`Overflow`.

## Interface
Parameters:
- `LEN_W`, default 4: width of the step-count field; maximum burst is 2^LEN_W−1 steps.

Ports:
- `Clk` input 1: single clock, rising edge.
- `Reset` input 1: asynchronous, active-low reset.
- `Req[1:0]` input 2: level request per requester; held high until that requester's `Done` pulse.
- `Len0`, `Len1` input LEN_W: step count for each requester; sampled at grant.
- `Clr[1:0]` input 2: per-requester flag, sampled at grant. 1 means clear the counter before stepping.
- `CntOutput` input 3: counter `Output`.
- `CntOverflow` input 1: counter `Overflow`, which is sticky until the counter is reset.
- `CntReset` output 1: drives the counter's synchronous active-high `Reset`.
- `CntEn` output 1: drives the counter's `En`.
- `Gnt[1:0]` output 2: one-hot current owner; 00 when idle.
- `Done[1:0]` output 2: one-cycle completion pulse to the owner.
- `Result` output 3: final gray value; valid with `Done`, held until the next `Done`.
- `ResOvf` output 1: `CntOverflow` sampled with `Result`.
- `Busy` output 1: high in any state other than IDLE.

## Operation
- FSM states: IDLE, CLEAR, RUN, DONE.
- **IDLE**
  - If any `Req` is high, arbitrate and register the winner.
  - Load `Gnt`, latch `Len`/`Clr` of the winner into `StepCnt`/`DoClr`.
  - Go to CLEAR if `DoClr`; else RUN if `StepCnt` ≠ 0; else DONE.
- **CLEAR**
  - `CntReset`=1 for exactly one cycle.
  - Then go to RUN if `StepCnt` ≠ 0, else DONE.
- **RUN**
  - `CntEn`=1 every cycle.
  - `StepCnt` decrements each cycle; leave to DONE when it reaches 1 (the last enabled cycle).
- **DONE**
  - Counter has settled. Register `Result`←`CntOutput` and `ResOvf`←`CntOverflow`.
  - Pulse `Done` at the bit matching `Gnt`, clear `Gnt`, return to IDLE.
- **Arbitration**
  - Round-robin over two requesters; `LastGnt` pointer updated at grant.
  - If both `Req` bits are high, the requester that is not `LastGnt` wins.
  - After reset `LastGnt`=1, so requester 0 wins the first tie.
- `Req` changes while a requester is granted have no effect until IDLE. Dropping `Req` mid-burst does not abort the burst.
- Without clear, stepping continues from the counter's current value and its sticky overflow.
- Reference gray sequence: 000→001→011→010→110→111→101→100→000. `Overflow` sets on the 100→000 step.

## Timing
- Reset (async, low) forces IDLE and zeros all outputs (`Gnt`, `Done`, `Result`, `ResOvf`, `CntReset`, `CntEn`, `Busy`) immediately; `LastGnt`=1.
- Reset mid-burst drops `CntEn` immediately. The counter keeps its value; the next grant's `Clr` handles cleanup.
- `CntReset` and `CntEn` are registered Moore outputs, never high in the same cycle.
- Latency from `Req` seen in IDLE to `Done`: 1 + `Clr` + `Len` + 1 cycles. Example: `Clr`=1, `Len`=3 → `Done` at cycle 6 after the grant edge.
- `Len`=0 with `Clr`=0 → `Done` in the cycle after grant with the unchanged counter value.
- Back-to-back: a pending `Req` is granted on the IDLE cycle immediately after DONE. There is a minimum 1 idle cycle between bursts.

## Structure
- Shared package `gray_ctrl_pkg` holds:
  - the state encoding constants (IDLE=2'd0, CLEAR=2'd1, RUN=2'd2, DONE=2'd3);
  - the gray sequence constants, used by the bench model.
- One sub-module, `rr_arb2`: two-way round-robin arbiter. Inputs are `Req` and `LastGnt`; output is a one-hot winner. It is combinational, and the pointer register stays in the controller.
- The counter itself is instantiated at the level above, not inside this block.

## Test plan
- Reset low mid-RUN (`Len`=7) → all outputs 0 in the same cycle. After release, `Req`[0] with `Clr`=1, `Len`=1 → `Result`=001.
- `Req`[0], `Clr`=1, `Len0`=3 → `CntReset` for 1 cycle, then `CntEn` for 3 cycles. `Done`[0] on cycle 6 with `Result`=010, `ResOvf`=0.
- `Req`[1], `Clr`=1, `Len1`=8 → `Result`=000, `ResOvf`=1.
- Chained without clear: `Len`=4 then `Len`=5 → `Result`=110, then `Result`=001 with `ResOvf`=1.
- `Req`=11 held after reset → grants in the order 0,1,0,1. Each `Done` goes only to its owner, and `Gnt` is never 11.
- `Len`=0, `Clr`=0 → `CntEn` never asserted, `Done` one cycle after grant, `Result` equal to the current `CntOutput`.
